// File: rtl/dds_cfg_pkg.sv
// Shared definitions for the DDS configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dds_cfg_pkg;

  localparam int unsigned PHASE_W_DEF = 24;

  // Phase steps as fractions of one full turn at the default width
  localparam logic [PHASE_W_DEF-1:0] PI_4 = PHASE_W_DEF'(1) << (PHASE_W_DEF - 3);
  localparam logic [PHASE_W_DEF-1:0] PI_2 = PHASE_W_DEF'(1) << (PHASE_W_DEF - 2);
  localparam logic [PHASE_W_DEF-1:0] PI   = PHASE_W_DEF'(1) << (PHASE_W_DEF - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low button; emits a 1-cycle pulse on an accepted press.
// Latency: 2 sync cycles + DEB_CYCLES stable cycles, then the pulse register.
// Backpressure: none; pulses are fire-and-forget.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Count stable cycles of a level that differs from the accepted one; accept it once the count is full
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset leaves the button in the released (high) state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level = acc_q;
  assign press = press_q;

endmodule

// File: rtl/dds_phase_cfg_ctrl.sv
// Steps the DDS phase offset / frequency index from two buttons and ships {POFF,PINC} words.
// Latency: press pulse to cfg_tvalid = 2 cycles from IDLE; one word per handshake.
// Backpressure: cfg_tvalid/cfg_tdata held while cfg_tready is low; further presses coalesce into one follow-up word.
module dds_phase_cfg_ctrl
  import dds_cfg_pkg::*;
#(
  parameter int unsigned         PHASE_W    = PHASE_W_DEF,
  parameter int unsigned         DEB_CYCLES = 1000000,
  parameter logic [PHASE_W-1:0]  FREQ0      = PHASE_W'(4096),
  parameter logic [PHASE_W-1:0]  FREQ1      = PHASE_W'(8192),
  parameter logic [PHASE_W-1:0]  FREQ2      = PHASE_W'(16384),
  parameter logic [PHASE_W-1:0]  FREQ3      = PHASE_W'(32768)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             key_step,
  input  logic                   btn_phase,
  input  logic                   btn_freq,
  output logic [2*PHASE_W-1:0]   cfg_tdata,
  output logic                   cfg_tvalid,
  input  logic                   cfg_tready,
  output logic [PHASE_W-1:0]     poff,
  output logic [1:0]             freq_idx,
  output logic                   busy
);

  localparam logic [PHASE_W-1:0] STEP_PI_4 = PHASE_W'(1) << (PHASE_W - 3);
  localparam logic [PHASE_W-1:0] STEP_PI_2 = PHASE_W'(1) << (PHASE_W - 2);
  localparam logic [PHASE_W-1:0] STEP_PI   = PHASE_W'(1) << (PHASE_W - 1);

  logic phase_press, freq_press, any_press;
  logic phase_lvl, freq_lvl;
  logic unused_lvl;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   poff_q, poff_d;
  logic [1:0]           freq_q, freq_d;
  logic                 pending_q, pending_d;
  logic [2*PHASE_W-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic [PHASE_W-1:0]   pinc_sel;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_phase),
    .level (phase_lvl),
    .press (phase_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_freq (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_freq),
    .level (freq_lvl),
    .press (freq_press)
  );

  assign unused_lvl = phase_lvl ^ freq_lvl;
  assign any_press  = phase_press | freq_press;

  // Frequency table lookup for the current index
  always_comb begin
    pinc_sel = FREQ0;
    case (freq_q)
      2'd0: pinc_sel = FREQ0;
      2'd1: pinc_sel = FREQ1;
      2'd2: pinc_sel = FREQ2;
      2'd3: pinc_sel = FREQ3;
      default: pinc_sel = FREQ0;
    endcase
  end

  // Button effects on poff/freq_idx apply in every state; the FSM snapshots them into the config word
  always_comb begin
    poff_d    = poff_q;
    freq_d    = freq_q;
    pending_d = pending_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    state_d   = state_q;

    if (phase_press) begin
      case (key_step)
        2'd0:    poff_d = poff_q + STEP_PI_4;
        2'd1:    poff_d = poff_q + STEP_PI_2;
        2'd2:    poff_d = poff_q + STEP_PI;
        default: poff_d = '0;
      endcase
    end
    if (freq_press) begin
      freq_d = freq_q + 2'd1;
    end

    case (state_q)
      ST_INIT: state_d = ST_LOAD;
      ST_IDLE: begin
        if (pending_q || any_press) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tdata_d   = {poff_q, pinc_sel};
        tvalid_d  = 1'b1;
        pending_d = 1'b0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tvalid_q && cfg_tready) begin
          tvalid_d = 1'b0;
          state_d  = (pending_q || any_press) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A press in the LOAD cycle is not in the snapshot, so it must survive the clear
    if (any_press) begin
      pending_d = 1'b1;
    end
  end

  // State registers; reset drops tvalid immediately and restarts with the INIT word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      poff_q    <= '0;
      freq_q    <= '0;
      pending_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      poff_q    <= poff_d;
      freq_q    <= freq_d;
      pending_q <= pending_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
    end
  end

  assign cfg_tdata  = tdata_q;
  assign cfg_tvalid = tvalid_q;
  assign poff       = poff_q;
  assign freq_idx   = freq_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_phase_cfg_ctrl.sv
// Self-checking bench for dds_phase_cfg_ctrl with a short debounce window.
// Latency: n/a.
// Backpressure: exercised via cfg_tready stalls.
module tb_dds_phase_cfg_ctrl;

  localparam int PW = 24;

  logic          clk;
  logic          rst_n;
  logic [1:0]    key_step;
  logic          btn_phase;
  logic          btn_freq;
  logic [47:0]   cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [PW-1:0] poff;
  logic [1:0]    freq_idx;
  logic          busy;

  dds_phase_cfg_ctrl #(.PHASE_W(PW), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_step   (key_step),
    .btn_phase  (btn_phase),
    .btn_freq   (btn_freq),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .poff       (poff),
    .freq_idx   (freq_idx),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          tests = 0;
  int          fails = 0;
  logic [47:0] got_q[$];
  bit          prev_stall = 1'b0;
  logic [47:0] prev_dat = '0;
  bit          rnd_rdy = 1'b0;

  typedef struct {
    bit          ph;
    bit          fr;
    logic [1:0]  key;
    logic [23:0] exp_poff;
    logic [23:0] exp_pinc;
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, collect handshakes, check stall stability, return after the rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (prev_stall) begin
        tests++;
        if (!(cfg_tvalid === 1'b1 && cfg_tdata === prev_dat)) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", cfg_tvalid, cfg_tdata, prev_dat);
        end
      end
      if (rst_n && cfg_tvalid && cfg_tready) got_q.push_back(cfg_tdata);
      prev_stall = rst_n && cfg_tvalid && !cfg_tready;
      prev_dat   = cfg_tdata;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit ph, input bit fr, input logic [1:0] k);
    key_step  = k;
    btn_phase = ~ph;
    btn_freq  = ~fr;
    tick(10);
    btn_phase = 1'b1;
    btn_freq  = 1'b1;
    tick(10);
  endtask

  task automatic expect_word(input string name, input logic [47:0] exp);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 300) begin
      if (rnd_rdy) cfg_tready = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    if (got_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no word expected %h", name, exp);
    end else begin
      chk(name, got_q.pop_front(), exp);
    end
  endtask

  task automatic expect_none(input string name);
    chk(name, 48'(got_q.size()), 48'd0);
    got_q.delete();
  endtask

  function automatic logic [23:0] pinc_of(input logic [1:0] idx);
    return 24'd4096 << idx;
  endfunction

  logic [23:0] m_poff;
  logic [1:0]  m_idx;
  logic [47:0] held;

  initial begin
    rst_n      = 1'b0;
    key_step   = 2'd0;
    btn_phase  = 1'b1;
    btn_freq   = 1'b1;
    cfg_tready = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 2'd0, 24'h200000, 24'd4096,  2'd0};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 24'h400000, 24'd4096,  2'd0};
    tbl[2] = '{1'b1, 1'b0, 2'd3, 24'h000000, 24'd4096,  2'd0};
    tbl[3] = '{1'b1, 1'b0, 2'd2, 24'h800000, 24'd4096,  2'd0};
    tbl[4] = '{1'b1, 1'b0, 2'd1, 24'hC00000, 24'd4096,  2'd0};
    tbl[5] = '{1'b1, 1'b0, 2'd1, 24'h000000, 24'd4096,  2'd0};
    tbl[6] = '{1'b0, 1'b1, 2'd0, 24'h000000, 24'd8192,  2'd1};
    tbl[7] = '{1'b0, 1'b1, 2'd0, 24'h000000, 24'd16384, 2'd2};
    tbl[8] = '{1'b0, 1'b1, 2'd0, 24'h000000, 24'd32768, 2'd3};
    tbl[9] = '{1'b0, 1'b1, 2'd0, 24'h000000, 24'd4096,  2'd0};

    // Reset state and the single INIT word
    tick(3);
    chk("rst_tvalid", 48'(cfg_tvalid), 48'd0);
    chk("rst_tdata",  cfg_tdata, 48'd0);
    chk("rst_poff",   48'(poff), 48'd0);
    chk("rst_idx",    48'(freq_idx), 48'd0);
    begin
      int vcnt;
      vcnt = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (cfg_tvalid) vcnt++;
      end
      chk("init_valid_cycles", 48'(vcnt), 48'd1);
    end
    expect_word("init_word", {24'h0, 24'd4096});
    chk("init_busy", 48'(busy), 48'd0);
    expect_none("init_single");

    // Table-driven single presses
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].ph, tbl[i].fr, tbl[i].key);
      expect_word($sformatf("tbl%0d_word", i), {tbl[i].exp_poff, tbl[i].exp_pinc});
      chk($sformatf("tbl%0d_poff", i), 48'(poff), 48'(tbl[i].exp_poff));
      chk($sformatf("tbl%0d_idx", i), 48'(freq_idx), 48'(tbl[i].exp_idx));
    end
    expect_none("tbl_no_extra");

    // Glitch rejection, then a held press producing exactly one word
    key_step  = 2'd0;
    btn_phase = 1'b0;
    tick(2);
    btn_phase = 1'b1;
    tick(20);
    expect_none("glitch_no_word");
    chk("glitch_poff", 48'(poff), 48'd0);
    press(1'b1, 1'b0, 2'd3);
    expect_word("held_word", {24'h0, 24'd4096});
    tick(20);
    expect_none("release_no_word");

    // Presses during a stalled SEND coalesce into one follow-up word
    cfg_tready = 1'b0;
    press(1'b1, 1'b0, 2'd3);
    held = cfg_tdata;
    chk("stall_valid", 48'(cfg_tvalid), 48'd1);
    press(1'b1, 1'b0, 2'd0);
    press(1'b1, 1'b0, 2'd0);
    press(1'b0, 1'b1, 2'd0);
    chk("stall_tdata", cfg_tdata, held);
    chk("stall_poff", 48'(poff), 48'h400000);
    chk("stall_idx", 48'(freq_idx), 48'd1);
    cfg_tready = 1'b1;
    expect_word("stall_first", {24'h0, 24'd4096});
    expect_word("stall_follow", {24'h400000, 24'd8192});
    tick(10);
    expect_none("stall_single_follow");

    // Reset while tvalid is high, then the INIT word again
    cfg_tready = 1'b0;
    press(1'b1, 1'b0, 2'd0);
    chk("pre_rst_valid", 48'(cfg_tvalid), 48'd1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_tvalid", 48'(cfg_tvalid), 48'd0);
    chk("midrst_poff", 48'(poff), 48'd0);
    chk("midrst_idx", 48'(freq_idx), 48'd0);
    got_q.delete();
    rst_n      = 1'b1;
    cfg_tready = 1'b1;
    expect_word("reinit_word", {24'h0, 24'd4096});
    tick(10);
    expect_none("reinit_single");

    // Randomized presses with random backpressure against an arithmetic model
    m_poff  = '0;
    m_idx   = '0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int          op;
      logic [1:0]  k;
      bit          ph;
      bit          fr;
      op = $urandom_range(0, 2);
      k  = 2'($urandom_range(0, 3));
      ph = (op != 1);
      fr = (op != 0);
      if (ph) m_poff = (k == 2'd3) ? 24'd0 : 24'((32'(m_poff) + (32'd1 << (21 + k))) % (32'd1 << 24));
      if (fr) m_idx = 2'((m_idx + 1) % 4);
      cfg_tready = 1'($urandom_range(0, 1));
      press(ph, fr, k);
      expect_word($sformatf("rnd%0d_word", i), {m_poff, pinc_of(m_idx)});
      chk($sformatf("rnd%0d_poff", i), 48'(poff), 48'(m_poff));
      chk($sformatf("rnd%0d_idx", i), 48'(freq_idx), 48'(m_idx));
    end
    rnd_rdy    = 1'b0;
    cfg_tready = 1'b1;
    tick(10);
    expect_none("rnd_no_extra");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
